// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
// Optional forwarding relief is enabled with the SCOREBOARD_FWD_EN macro.
package reg_scoreboard_pkg;

  localparam int unsigned REG_CNT  = 16;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned PC_IDX   = 15;
  localparam int unsigned SB_CNT_W = 2;

  typedef logic [REG_CNT-1:0] reg_mask_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter with synchronous clear,
// nonzero flag and a combinational underflow pulse.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nz,
  output logic             o_unf
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    o_unf     = 1'b0;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != CntMax) w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      // Retiring with nothing outstanding is a protocol error, not a wrap.
      if (r_cnt == '0) o_unf = 1'b1;
      else             w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  assign o_cnt = r_cnt;
  assign o_nz  = |r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard scoreboard for the 16-entry register file; r15 (PC) is untracked.
// Define SCOREBOARD_FWD_EN to let a retiring last write release RAW/full stalls.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iv,
  input  logic [REG_AW-1:0] ir1,
  input  logic [REG_AW-1:0] ir2,
  input  logic              ir1v,
  input  logic              ir2v,
  input  logic              iwe,
  input  logic [REG_AW-1:0] iwa,
  input  logic              flush,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  output logic              stall,
  output logic              fire,
  output logic [REG_CNT-1:0] pending,
  output logic              err
);

  localparam logic [CNT_W-1:0] CntMax = '1;
`ifdef SCOREBOARD_FWD_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
`endif

  logic [CNT_W-1:0] w_cnt [REG_CNT];
  reg_mask_t        w_nz;
  reg_mask_t        w_unf;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_full;
  logic             w_stall;
  logic             w_fire;
  logic             r_err;

  for (genvar gi = 0; gi < int'(PC_IDX); gi++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (flush),
      .i_inc (w_fire && iwe && (iwa == REG_AW'(gi))),
      .i_dec (we && (wa == REG_AW'(gi))),
      .o_cnt (w_cnt[gi]),
      .o_nz  (w_nz[gi]),
      .o_unf (w_unf[gi])
    );
  end

  assign w_cnt[PC_IDX] = '0;
  assign w_nz[PC_IDX]  = 1'b0;
  assign w_unf[PC_IDX] = 1'b0;

  always_comb begin
    w_haz1 = ir1v && (w_cnt[ir1] != '0);
    w_haz2 = ir2v && (w_cnt[ir2] != '0);
    w_full = iwe && (w_cnt[iwa] == CntMax);
`ifdef SCOREBOARD_FWD_EN
    // Reg file write-before-read delivers the retiring value this same cycle.
    if (we && (wa == ir1) && (w_cnt[ir1] == CntOne)) w_haz1 = 1'b0;
    if (we && (wa == ir2) && (w_cnt[ir2] == CntOne)) w_haz2 = 1'b0;
    if (we && (wa == iwa)) w_full = 1'b0;
`endif
  end

  assign w_stall = iv && (w_haz1 || w_haz2 || w_full) && !flush;
  assign w_fire  = iv && !w_stall && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= r_err | (|w_unf);
  end

  assign stall   = w_stall;
  assign fire    = w_fire;
  assign pending = w_nz;
  assign err     = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: stall/fire vectors plus a pending/err scoreboard.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic       iv;
    logic [3:0] ir1;
    logic       ir1v;
    logic [3:0] ir2;
    logic       ir2v;
    logic       iwe;
    logic [3:0] iwa;
    logic       flush;
    logic       we;
    logic [3:0] wa;
    logic       stall;
    logic       fire;
  } vec_t;

  typedef struct {
    logic [15:0] pend;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv, ir1v, ir2v, iwe, flush, we;
  logic [3:0]  ir1, ir2, iwa, wa;
  logic        stall, fire, err;
  logic [15:0] pending;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   mcnt [16];
  logic merr;
  exp_t q [$];
  vec_t tbl [7];

  reg_scoreboard #(
    .CNT_W (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .iv      (iv),
    .ir1     (ir1),
    .ir2     (ir2),
    .ir1v    (ir1v),
    .ir2v    (ir2v),
    .iwe     (iwe),
    .iwa     (iwa),
    .flush   (flush),
    .we      (we),
    .wa      (wa),
    .stall   (stall),
    .fire    (fire),
    .pending (pending),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int v_iv, input int v_ir1, input int v_ir1v,
                              input int v_ir2, input int v_ir2v, input int v_iwe,
                              input int v_iwa, input int v_flush, input int v_we,
                              input int v_wa, input int v_stall, input int v_fire);
    vec_t v;
    v.iv    = (v_iv != 0);
    v.ir1   = 4'(v_ir1);
    v.ir1v  = (v_ir1v != 0);
    v.ir2   = 4'(v_ir2);
    v.ir2v  = (v_ir2v != 0);
    v.iwe   = (v_iwe != 0);
    v.iwa   = 4'(v_iwa);
    v.flush = (v_flush != 0);
    v.we    = (v_we != 0);
    v.wa    = 4'(v_wa);
    v.stall = (v_stall != 0);
    v.fire  = (v_fire != 0);
    return v;
  endfunction

  task automatic chk(input string name, input string what, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", name, what, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iv = v.iv; ir1 = v.ir1; ir1v = v.ir1v; ir2 = v.ir2; ir2v = v.ir2v;
    iwe = v.iwe; iwa = v.iwa; flush = v.flush; we = v.we; wa = v.wa;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.pend = '0;
    for (int i = 0; i < 15; i++) e.pend[i] = (mcnt[i] != 0);
    e.err = merr;
    return e;
  endfunction

  // Spec-level reference: r15 untracked, flush clears and discards retires.
  task automatic model_step(input vec_t v);
    if (v.flush) begin
      for (int i = 0; i < 16; i++) mcnt[i] = 0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        bit inc = v.fire && v.iwe && (int'(v.iwa) == i);
        bit dec = v.we && (int'(v.wa) == i);
        if (inc && !dec) mcnt[i]++;
        else if (dec && !inc) begin
          if (mcnt[i] == 0) merr = 1'b1;
          else              mcnt[i]--;
        end
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    drive(v);
    #3;
    chk(name, "stall", {15'd0, stall}, {15'd0, v.stall});
    chk(name, "fire", {15'd0, fire}, {15'd0, v.fire});
    model_step(v);
    q.push_back(model_exp());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk(name, "pending", pending, e.pend);
    chk(name, "err", {15'd0, err}, {15'd0, e.err});
  endtask

  initial begin
    tbl[0] = mk(1, 3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1);
    tbl[1] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[2] = mk(1, 3, 0, 3, 0, 1, 3, 0, 0, 0, 0, 1);
    tbl[3] = mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[5] = mk(1, 15, 1, 0, 0, 1, 15, 0, 0, 0, 0, 1);
    tbl[6] = mk(1, 15, 1, 15, 1, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    merr  = 1'b0;
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "pending", pending, 16'h0000);
    chk("reset", "err", {15'd0, err}, 16'h0000);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Leave r3 at 2 and err set, then reset asynchronously mid-cycle.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0), "pre-reset underflow");
    drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 reset = 1'b0;
    #1;
    chk("t1 async reset", "pending", pending, 16'h0000);
    chk("t1 async reset", "err", {15'd0, err}, 16'h0000);
    chk("t1 async reset", "stall", {15'd0, stall}, 16'h0000);
    chk("t1 async reset", "fire", {15'd0, fire}, 16'h0001);
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    merr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    apply(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1), "t2 issue w5");
    apply(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "t2 raw r5");
    apply(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, FWD ? 0 : 1, FWD ? 1 : 0), "t2 retire r5");
    apply(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "t2 after retire");

    for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1), "t3 fill r2");
    for (int i = 0; i < 2; i++) apply(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0), "t3 full");
    apply(mk(1, 0, 0, 0, 0, 1, 2, 0, 1, 2, FWD ? 0 : 1, FWD ? 1 : 0), "t3 full retire");
    apply(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, FWD ? 1 : 0, FWD ? 0 : 1), "t3 refill");
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0), "t3 drain");

    apply(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1), "t4 issue w7");
    apply(mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0, 1), "t4 issue+retire r7");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0), "t4 drain r7");

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0), "t5 retire r15");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0), "t5 underflow r9");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "t5 err sticky");

    for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1), "t6 fill r1");
    apply(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1), "t6 issue w4");
    apply(mk(1, 1, 1, 4, 1, 1, 1, 1, 1, 4, 0, 0), "t6 flush");
    apply(mk(1, 15, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1), "t6 post flush");
    apply(mk(1, 15, 1, 15, 1, 1, 15, 0, 0, 0, 0, 1), "t6 r15 untracked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
